// File: rtl/tuart_pkg.sv
// Shared types and frame constants for the buffered 8N1 UART transmitter.
package tuart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT
    } tx_state_t;

    localparam int DATA_BITS = 8;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tuart_fifo.sv
// Synchronous byte FIFO; only pointers and count are reset, storage keeps stale data.
module tuart_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tuart_fifo_tx.sv
// Buffered 8N1 UART transmitter: bus strobes feed a FIFO, the FSM drains it LSB-first on TX.
module tuart_fifo_tx
    import tuart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [7:0] DATA,
    input  logic       START,
    output logic       BUSY,
    output logic       FULL,
    output logic       OVERRUN,
    output logic       TX
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t     state;
    logic [CW-1:0] baud;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          baud_done;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    tuart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (START),
        .pop   (pop),
        .wdata (DATA),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_done = (baud == BAUD_LAST);

    // Pop happens when idle, or on the final stop-bit cycle so queued frames run back to back.
    assign pop = ~fifo_empty &
                 ((state == S_IDLE) | ((state == S_STOP_BIT) & baud_done));

    assign FULL = fifo_full;
    assign BUSY = (state != S_IDLE) | (fifo_count != '0);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            baud    <= '0;
            shift   <= '0;
            bit_idx <= '0;
            TX      <= STOP_LEVEL;
            OVERRUN <= 1'b0;
        end else begin
            if (START && fifo_full) begin
                OVERRUN <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    TX <= STOP_LEVEL;
                    if (!fifo_empty) begin
                        shift <= fifo_rdata;
                        baud  <= '0;
                        state <= S_START_BIT;
                        TX    <= START_LEVEL;
                    end
                end
                S_START_BIT: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA_BITS;
                        TX      <= shift[0];
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                S_DATA_BITS: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_STOP_BIT;
                            TX    <= STOP_LEVEL;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            TX      <= shift[1];
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                S_STOP_BIT: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            shift <= fifo_rdata;
                            state <= S_START_BIT;
                            TX    <= START_LEVEL;
                        end else begin
                            state <= S_IDLE;
                            TX    <= STOP_LEVEL;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    TX    <= STOP_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuart_fifo_tx.sv
// Directed bench for tuart_fifo_tx: per-cycle TX/BUSY expectations built from hand-derived frames.
module tb_tuart_fifo_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy;
    logic       full;
    logic       overrun;
    logic       tx;

    int total = 0;
    int bad   = 0;

    // Expected TX level and BUSY per sampled cycle (sample j = after push edge k+j)
    logic [0:0] exp_q[$];
    logic [0:0] busy_q[$];

    always #5 clk = ~clk;

    tuart_fifo_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .HCLK    (clk),
        .HRESET  (rst),
        .DATA    (data),
        .START   (start),
        .BUSY    (busy),
        .FULL    (full),
        .OVERRUN (overrun),
        .TX      (tx)
    );

    task automatic add_level(input logic lvl);
        repeat (CPB) begin
            exp_q.push_back(lvl);
            busy_q.push_back(1'b1);
        end
    endtask

    task automatic add_frame(input logic [7:0] b);
        add_level(1'b0);
        for (int i = 0; i < 8; i++) add_level(b[i]);
        add_level(1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        busy_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1)      begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (full !== 1'b0)    begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        exp_q.push_back(1'b1); busy_q.push_back(1'b1);
        add_frame(8'hA5);
        exp_q.push_back(1'b1); busy_q.push_back(1'b0);
        start = 1'b1;
        data  = 8'hA5;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            start = 1'b0;
            total++; if (tx !== exp_q[j])    begin bad++; $display("FAIL single_tx j=%0d got=%b want=%b", j, tx, exp_q[j]); end
            total++; if (busy !== busy_q[j]) begin bad++; $display("FAIL single_busy j=%0d got=%b want=%b", j, busy, busy_q[j]); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        exp_q.push_back(1'b1); busy_q.push_back(1'b1);
        add_frame(8'h01);
        add_frame(8'h02);
        add_frame(8'h03);
        exp_q.push_back(1'b1); busy_q.push_back(1'b0);
        start = 1'b1;
        data  = 8'h01;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            total++; if (tx !== exp_q[j])    begin bad++; $display("FAIL b2b_tx j=%0d got=%b want=%b", j, tx, exp_q[j]); end
            total++; if (busy !== busy_q[j]) begin bad++; $display("FAIL b2b_busy j=%0d got=%b want=%b", j, busy, busy_q[j]); end
            if (j + 1 < 3) begin
                start = 1'b1;
                data  = 8'(j + 2);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_fill_overrun();
        apply_reset();
        exp_q.push_back(1'b1); busy_q.push_back(1'b1);
        for (int i = 0; i < 17; i++) add_frame(8'(8'h10 + i));
        exp_q.push_back(1'b1); busy_q.push_back(1'b0);
        start = 1'b1;
        data  = 8'h10;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            total++; if (tx !== exp_q[j])    begin bad++; $display("FAIL fill_tx j=%0d got=%b want=%b", j, tx, exp_q[j]); end
            total++; if (busy !== busy_q[j]) begin bad++; $display("FAIL fill_busy j=%0d got=%b want=%b", j, busy, busy_q[j]); end
            if (j == 15) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full15 got=%b want=0", full); end
            end
            if (j == 16) begin
                total++; if (full !== 1'b1)    begin bad++; $display("FAIL fill_full16 got=%b want=1", full); end
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fill_ovr16 got=%b want=0", overrun); end
            end
            if (j == 17) begin
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL fill_ovr17 got=%b want=1", overrun); end
            end
            if (j == 40) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full40 got=%b want=1", full); end
            end
            if (j == 41) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full41 got=%b want=0", full); end
            end
            if (j + 1 < 17) begin
                start = 1'b1;
                data  = 8'(8'h10 + j + 1);
            end else if (j + 1 == 17) begin
                start = 1'b1;
                data  = 8'hEE;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_full_pop_same_edge();
        apply_reset();
        exp_q.push_back(1'b1); busy_q.push_back(1'b1);
        for (int i = 0; i < 17; i++) add_frame(8'(8'h20 + i));
        add_frame(8'h77);
        exp_q.push_back(1'b1); busy_q.push_back(1'b0);
        start = 1'b1;
        data  = 8'h20;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            total++; if (tx !== exp_q[j])    begin bad++; $display("FAIL fps_tx j=%0d got=%b want=%b", j, tx, exp_q[j]); end
            total++; if (busy !== busy_q[j]) begin bad++; $display("FAIL fps_busy j=%0d got=%b want=%b", j, busy, busy_q[j]); end
            if (j == 40) begin
                total++; if (full !== 1'b1)    begin bad++; $display("FAIL fps_full40 got=%b want=1", full); end
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fps_ovr40 got=%b want=0", overrun); end
            end
            if (j == 41) begin
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL fps_ovr41 got=%b want=1", overrun); end
                total++; if (full !== 1'b0)    begin bad++; $display("FAIL fps_full41 got=%b want=0", full); end
            end
            if (j == 42) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL fps_full42 got=%b want=1", full); end
            end
            if (j + 1 <= 16) begin
                start = 1'b1;
                data  = 8'(8'h20 + j + 1);
            end else if (j + 1 == 41) begin
                start = 1'b1;
                data  = 8'hEE;
            end else if (j + 1 == 42) begin
                start = 1'b1;
                data  = 8'h77;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        exp_q.push_back(1'b1); busy_q.push_back(1'b1);
        add_frame(8'h55);
        add_frame(8'h00);
        add_frame(8'h33);
        start = 1'b1;
        data  = 8'h55;
        for (int j = 0; j <= 55; j++) begin
            @(negedge clk);
            total++; if (tx !== exp_q[j]) begin bad++; $display("FAIL rstmid_tx j=%0d got=%b want=%b", j, tx, exp_q[j]); end
            if (j + 1 < 3) begin
                start = 1'b1;
                data  = (j == 0) ? 8'h00 : 8'h33;
            end else begin
                start = 1'b0;
            end
        end
        rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1)   begin bad++; $display("FAIL rstmid_async_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b want=0", full); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            total++; if (tx !== 1'b1)   begin bad++; $display("FAIL rstmid_after_tx j=%0d got=%b want=1", j, tx); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_after_busy j=%0d got=%b want=0", j, busy); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            exp_q.delete();
            busy_q.delete();
            exp_q.push_back(1'b1); busy_q.push_back(1'b1);
            add_frame(8'(n + 1));
            exp_q.push_back(1'b1); busy_q.push_back(1'b0);
            start = 1'b1;
            data  = 8'(n + 1);
            for (int j = 0; j < exp_q.size(); j++) begin
                @(negedge clk);
                start = 1'b0;
                total++; if (tx !== exp_q[j])    begin bad++; $display("FAIL wrap_tx n=%0d j=%0d got=%b want=%b", n, j, tx, exp_q[j]); end
                total++; if (busy !== busy_q[j]) begin bad++; $display("FAIL wrap_busy n=%0d j=%0d got=%b want=%b", n, j, busy, busy_q[j]); end
            end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL wrap_overrun got=%b want=0", overrun); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_overrun();
        test_full_pop_same_edge();
        test_reset_mid_frame();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tuart_fifo_tx.md
# tuart_fifo_tx

Buffered 8N1 UART transmitter that replaces the bare trivial UART behind the AHB UART bridge. It consumes the bridge's one-cycle byte-write strobe (DATA/START), queues bytes in an internal FIFO, and serializes them LSB-first on TX at a fixed baud divisor. Unlike the bare trivial UART, back-to-back bus writes are never lost while a frame is in flight, as long as the FIFO has room.

## Interface
Parameters:
- CLKS_PER_BIT, 434, HCLK cycles per serial bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 16, byte entries; power of two, >= 2.

Ports:
- HCLK  input  1  system clock; all logic on the rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- DATA  input  8  byte to enqueue; sampled only when START=1.
- START  input  1  one-cycle push strobe from the bus bridge.
- BUSY  output  1  1 while the FIFO is non-empty or a frame is in progress.
- FULL  output  1  1 when the FIFO holds FIFO_DEPTH bytes.
- OVERRUN  output  1  sticky; set when START arrives while FULL; cleared only by reset.
- TX  output  1  serial line, idle high.

## Operation
- Push: START=1 and FULL=0 at an edge writes DATA at the write pointer and increments the count.
- Full handling: START=1 with FULL=1 drops the byte, sets OVERRUN, and leaves the FIFO unchanged. FULL is judged on the pre-edge count, even if a pop happens on the same edge.
- Simultaneous push and pop on a non-full FIFO: both take effect; count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- FSM states:
  - IDLE: TX=1. If FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START_BIT.
  - START_BIT: TX=0 for CLKS_PER_BIT cycles, then go to DATA_BITS with bit index 0.
  - DATA_BITS: TX=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP_BIT.
  - STOP_BIT: TX=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START_BIT (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on terminal count.
- BUSY = (state != IDLE) | (count != 0).

## Timing
- Reset values: TX=1, BUSY=0, FULL=0, OVERRUN=0, count=0, pointers=0, state=IDLE.
- HRESET asserted mid-frame:
  - TX returns to 1 immediately (asynchronously).
  - The frame is truncated and FIFO contents are discarded.
- Latency: a push at edge k into an empty, idle block pops at edge k+1, so TX is low from edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Queued bytes are sent back to back with no gap.
- FULL, BUSY and OVERRUN are registered or derived from registered state; no combinational path from START or DATA to any output.
- DATA must be valid in the cycle START=1. No other handshake: the bridge does not wait on BUSY.

## Structure
- Package tuart_pkg holds:
  - the state enum (IDLE, START_BIT, DATA_BITS, STOP_BIT);
  - DATA_BITS=8;
  - frame constants: start level 0, stop level 1.
- Sub-module tuart_fifo: synchronous FIFO, FIFO_DEPTH x 8.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Async active-high reset on pointers and count only; the storage array is not reset.
- Top level holds the FSM, baud counter, shift register, bit index and OVERRUN.

## Test plan
- Reset, then one push of 8'hA5 at CLKS_PER_BIT=4 -> TX low from the next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles. BUSY deasserts on the cycle after the stop bit ends.
- Push 8'h01, 8'h02, 8'h03 on consecutive cycles -> three contiguous 40-cycle frames in order, no idle cycle between them, BUSY=1 throughout.
- Push 17 bytes on consecutive cycles with FIFO_DEPTH=16:
  - The first byte pops at its push+1 edge.
  - FULL asserts once 16 bytes are queued.
  - The 18th push is dropped and OVERRUN=1.
  - All 17 accepted bytes are transmitted in order.
- FIFO full while a stop bit ends, with a push on the same cycle as the pop -> push dropped, OVERRUN=1, count goes to 15.
- Assert HRESET during DATA_BITS of the second of three queued bytes -> TX=1 immediately, BUSY=0, FULL=0. No further frames are sent after reset release.
- Wrap-around: 40 single pushes of incrementing bytes, each sent before the next push -> bytes received in order across pointer wrap, OVERRUN stays 0.
